// File: rtl/wb_trace_pkg.sv
// Shared types, constants and elaboration helpers for the writeback trace UART.
// Optional feature macro: WB_TRACE_SYNC_EN (prefix every word with a 0xA5 sync byte).
package wb_trace_pkg;

    // Transmit FSM states: one full 8N1 frame is START -> DATA -> STOP.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Width of a captured writeback value.
    localparam int WORD_W = 32;

    // Byte sent ahead of each word when the sync option is built in.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Clock cycles per serial bit; integer division, remainder is ignored.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Bytes on the wire per captured word: four data bytes, plus the sync byte if enabled.
    function automatic int bytes_per_word();
`ifdef WB_TRACE_SYNC_EN
        return 5;
`else
        return 4;
`endif
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Word FIFO between the writeback capture port and the UART shifter.
// A push while full is dropped and reported on 'dropped'; fullness comes from the
// registered count, so a same-cycle pop never makes room for a push.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              dropped
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("wb_trace_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_req && !full;
    assign do_pop   = pop && !empty;
    assign dropped  = push_req && full;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the array has no reset; contents are only read after being written, and leaving it
    // unreset lets it map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_trace_uart.sv
// Writeback trace exporter: captures wb_data on wb_valid, queues words and sends each one
// little-endian over an 8N1 UART line with no gap between bytes or words.
// Optional feature macro: WB_TRACE_SYNC_EN (adds a leading 0xA5 byte to every word).
module wb_trace_uart
    import wb_trace_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [WORD_W-1:0] wb_data,
    output logic              uart_tx,
    output logic              busy,
    output logic              overflow
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int BPW   = bytes_per_word();
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

    if (CPB < 2) begin : g_bad_baud
        $error("wb_trace_uart: CLK_HZ/BAUD must be at least 2");
    end

    tx_state_t         state;
    logic [WORD_W-1:0] shreg;
    logic [2:0]        byte_idx;
    logic [2:0]        bit_idx;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tx_q;
    logic              overflow_q;

    logic [WORD_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_dropped;
    logic              pop;

    logic              bit_end;
    logic              last_byte;
    logic              is_sync_byte;
    logic [7:0]        cur_byte;

    wb_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_req  (wb_valid),
        .push_data (wb_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped)
    );

    assign bit_end   = (bit_cnt == CNT_W'(CPB - 1));
    assign last_byte = (byte_idx == 3'(BPW - 1));

`ifdef WB_TRACE_SYNC_EN
    assign is_sync_byte = (byte_idx == 3'd0);
`else
    assign is_sync_byte = 1'b0;
`endif

    // A word is taken from the FIFO either from idle or at the end of the last stop bit,
    // which is what keeps back-to-back words gapless.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && bit_end && last_byte));

    // Byte currently on the wire: the sync marker or the low byte of the shifter.
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        cur_byte = shreg[7:0];
        if (is_sync_byte) cur_byte = SYNC_BYTE;
    end

    // Transmit FSM with registered line output and a single reloading bit-period counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= fifo_head;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_q    <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 3'd1;
                            if (!is_sync_byte) shreg <= {8'h00, shreg[WORD_W-1:8]};
                            tx_q  <= 1'b0;
                            state <= START;
                        end else if (pop) begin
                            shreg    <= fifo_head;
                            byte_idx <= '0;
                            tx_q     <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             overflow_q <= 1'b0;
        else if (fifo_dropped) overflow_q <= 1'b1;
    end

    assign uart_tx  = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_wb_trace_uart.sv
// Self-checking bench for wb_trace_uart: a UART receiver model decodes the line and compares
// each byte against a scoreboard queue filled when words are driven.
// Honours WB_TRACE_SYNC_EN to expect the 0xA5 sync byte.
module tb_wb_trace_uart;

    localparam int CPB       = 10;
    localparam int FRAME_CYC = 10 * CPB;
`ifdef WB_TRACE_SYNC_EN
    localparam int BPW = 5;
`else
    localparam int BPW = 4;
`endif
    localparam int WORD_CYC = BPW * FRAME_CYC;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        uart_tx;
    logic        busy;
    logic        overflow;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rx_frames = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    wb_trace_uart #(
        .CLK_HZ     (100_000_000),
        .BAUD       (10_000_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic push_exp(input logic [31:0] w);
`ifdef WB_TRACE_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic wait_idle(input int max_cyc, output int t_end);
        int n;
        n = 0;
        while (busy && (n < max_cyc)) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
        t_end = cyc;
    endtask

    // Receiver model: detect start bit, sample mid-bit, compare against scoreboard.
    initial begin : rx_mon
        int         cnt;
        int         k;
        logic       active;
        logic [7:0] sh;
        active = 1'b0;
        cnt    = 0;
        sh     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (uart_tx == 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                cnt++;
                if ((cnt % CPB) == (CPB / 2 - 1)) begin
                    k = cnt / CPB;
                    if (k == 0) begin
                        check("rx_start_bit", uart_tx, 1'b0);
                    end else if (k <= 8) begin
                        sh[k-1] = uart_tx;
                    end else begin
                        check("rx_stop_bit", uart_tx, 1'b1);
                        active = 1'b0;
                        rx_frames++;
                        if (exp_q.size() == 0) check("rx_extra_byte", exp_q.size(), 1);
                        else check("rx_byte", sh, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         t_end;
        int         f0;
        int         n;
        logic [7:0] b1;

        reset    = 1'b1;
        wb_valid = 1'b0;
        wb_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", uart_tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single word: latency, byte order, word length, busy release.
        start_q.delete();
        f0       = rx_frames;
        wb_valid = 1'b1;
        wb_data  = 32'hDEADBEEF;
        push_exp(32'hDEADBEEF);
        @(negedge clk);
        wb_valid = 1'b0;
        check("t1_busy_after_push", busy, 1'b1);
        check("t1_tx_high_before_pop", uart_tx, 1'b1);
        @(negedge clk);
        check("t1_tx_low_after_pop", uart_tx, 1'b0);
        wait_idle(WORD_CYC + 200, t_end);
        check("t1_frames", rx_frames - f0, BPW);
        if (start_q.size() > 0) check("t1_word_cycles", t_end - start_q[0], WORD_CYC);
        else check("t1_no_start_seen", start_q.size(), 1);
        check("t1_tx_idle", uart_tx, 1'b1);
        check("t1_scoreboard_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        // Back-to-back words: contiguous frames.
        start_q.delete();
        f0       = rx_frames;
        wb_valid = 1'b1;
        wb_data  = 32'h00000001;
        push_exp(32'h00000001);
        @(negedge clk);
        wb_data  = 32'h80000000;
        push_exp(32'h80000000);
        @(negedge clk);
        wb_valid = 1'b0;
        wait_idle(2 * WORD_CYC + 200, t_end);
        check("t2_frames", rx_frames - f0, 2 * BPW);
        for (int i = 1; i < start_q.size(); i++)
            check("t2_frame_gap", start_q[i] - start_q[i-1], FRAME_CYC);
        check("t2_scoreboard_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        // Overflow with depth 4: word 1 popped, 2..5 queued, 6..8 dropped.
        f0 = rx_frames;
        for (int i = 1; i <= 8; i++) begin
            wb_valid = 1'b1;
            wb_data  = 32'(i);
            if (i <= 5) push_exp(32'(i));
            @(negedge clk);
            check("t3_overflow", overflow, (i >= 6));
        end
        wb_valid = 1'b0;
        wait_idle(5 * WORD_CYC + 200, t_end);
        check("t3_frames", rx_frames - f0, 5 * BPW);
        check("t3_overflow_sticky", overflow, 1'b1);
        check("t3_scoreboard_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        // Reset during data bit 3 of byte 1.
        wb_valid = 1'b1;
        wb_data  = 32'h11223344;
        push_exp(32'h11223344);
        @(negedge clk);
        wb_valid = 1'b0;
        n = 0;
        while ((uart_tx !== 1'b0) && (n < 10)) begin
            @(negedge clk);
            n++;
        end
        check("t4_frame_started", uart_tx, 1'b0);
        repeat (FRAME_CYC + 4 * CPB + CPB / 2) @(negedge clk);
`ifdef WB_TRACE_SYNC_EN
        b1 = 8'h44;
`else
        b1 = 8'h33;
`endif
        check("t4_tx_bit3_before_reset", uart_tx, b1[3]);
        #2 reset = 1'b1;
        #1;
        check("t4_tx_after_reset", uart_tx, 1'b1);
        check("t4_busy_after_reset", busy, 1'b0);
        check("t4_overflow_after_reset", overflow, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        f0       = rx_frames;
        wb_valid = 1'b1;
        wb_data  = 32'hCAFEF00D;
        push_exp(32'hCAFEF00D);
        @(negedge clk);
        wb_valid = 1'b0;
        wait_idle(WORD_CYC + 200, t_end);
        check("t4_frames", rx_frames - f0, BPW);
        check("t4_scoreboard_empty", exp_q.size(), 0);
        check("t4_tx_idle", uart_tx, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_trace_uart.md
# wb_trace_uart

Writeback trace exporter for the RV32I core. It captures 32-bit writeback values presented alongside `wb_data` from the processor top, buffers them in a small FIFO and serialises each word over a single 8N1 UART TX line. This lets a host log the retired-result stream without a VIO or ILA. It sits beside the `RISC_V_PROCESSOR` instance at board top level and only consumes what the core writes back.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: input clock frequency in Hz.
- `BAUD`, 115_200: line rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer division) must be ≥ 2, otherwise elaboration fails.
- `FIFO_DEPTH`, 16: word entries. Must be a power of two and ≥ 2.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `wb_valid`, input, 1: `wb_data` holds a value to capture this cycle.
- `wb_data`, input, 32: writeback value.
- `uart_tx`, output, 1: serial line; idles high.
- `busy`, output, 1: high while the FIFO is non-empty or a frame is in progress.
- `overflow`, output, 1: sticky flag; set when a word is dropped.

## Operation
- **Capture**
  - On each cycle with `wb_valid=1` and FIFO not full, `wb_data` is pushed.
  - If the FIFO is full, the word is dropped and `overflow` is set to 1. `overflow` stays set until reset.
  - Full is evaluated from the registered count. A push while full is dropped even if a pop happens in the same cycle.
- **Transmit FSM**
  - States: IDLE, START, DATA, STOP.
  - IDLE → START when no word is in flight and the FIFO is non-empty. The FSM pops the head word into a 32-bit shift register and sets the byte index to 0.
  - START drives 0 for `CLKS_PER_BIT` cycles, then goes to DATA.
  - DATA drives 8 bits, LSB first, each for `CLKS_PER_BIT` cycles, then goes to STOP.
  - STOP drives 1 for `CLKS_PER_BIT` cycles. If bytes remain in the word, go to START with the next byte. Otherwise pop the next word if available and go to START; if not, go to IDLE.
  - There is no idle gap between bytes or between back-to-back words.
- **Byte order:** little-endian. Order is `wb_data[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- A single bit-period counter counts 0..CLKS_PER_BIT-1 and is reloaded on every bit boundary.

## Timing
- **Reset values:** `uart_tx=1`, `busy=0`, `overflow=0`. FSM is in IDLE, FIFO pointers and count are 0, counters are 0.
- **Latency:** a word pushed into an empty, idle block at edge N is popped at edge N+1. `uart_tx` goes low after edge N+1. `busy` goes high after edge N.
- **Frame length:** 10·`CLKS_PER_BIT` cycles per byte. A word takes 40·`CLKS_PER_BIT` cycles (50·`CLKS_PER_BIT` with the sync option enabled).
- **`busy` deassertion:** `busy` falls on the edge that ends the last STOP bit with the FIFO empty.
- **Reset mid-frame:** the frame is truncated immediately and asynchronously. `uart_tx` returns to 1 and queued words are discarded.
- **Push/pop in the same cycle (not full):** count is unchanged and both operations take effect.
- **Pointers:** FIFO pointers wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.

## Configuration
- `WB_TRACE_SYNC_EN` defined: each word is preceded by the sync byte 0xA5, giving 5 bytes per word. The byte index runs 0..4, and index 0 transmits 0xA5.
- `WB_TRACE_SYNC_EN` undefined: 4 bytes per word, no sync byte. Everything else is identical.

## Structure
- **Package `wb_trace_pkg`:**
  - FSM state enum `tx_state_t`.
  - `SYNC_BYTE = 8'hA5`.
  - Function `clks_per_bit(clk_hz, baud)`.
  - Function computing `BYTES_PER_WORD` (4 or 5).
- **Sub-module `wb_trace_fifo`:** synchronous FIFO with push/pop/full/empty and a drop-on-full policy. The FSM and shifter live in `wb_trace_uart`.

## Test plan
Benches use `CLK_HZ=100_000_000` and `BAUD=10_000_000`, i.e. 10 clocks per bit.
1. **Single word:** `wb_data=32'hDEADBEEF`, 1-cycle valid → bytes EF, BE, AD, DE decoded LSB-first. 400 cycles from first start bit to end of last stop bit. `busy` then falls and `uart_tx=1`.
2. **Back-to-back:** two words 0x00000001 and 0x80000000 pushed on consecutive cycles → 8 contiguous frames with no idle gap. Byte stream is 01, 00, 00, 00, 00, 00, 00, 80.
3. **Overflow:** `FIFO_DEPTH=4`, valid held high for 8 cycles with values 1..8 → words 1–5 are transmitted (1 popped at edge N+1, 2–5 queued), 6–8 are dropped. `overflow=1` from the first drop and it stays set.
4. **Reset mid-frame:** assert `reset` during the DATA bit 3 of byte 1 → `uart_tx=1` immediately, with `busy=0`, `overflow=0`. A new word after release transmits cleanly.
5. **Sync option:** with `WB_TRACE_SYNC_EN`, word 0x12345678 → bytes A5, 78, 56, 34, 12, 500 cycles in total.
